board_renderer: RTL and testbench
=================================

# board_renderer

Parametrised Connect-Four board pixel renderer. It sits between the VGA timing generator and the DAC/HDMI encoder. It maps each pixel coordinate to a board cell and draws round discs on a blue board. A header row shows a cursor disc over the selected column, and winning cells blink. Output is a two-stage registered pipeline with a frame-based blink counter.

## Interface
- `CELL_SIZE`, 64: cell edge in pixels, power of two not required, ≥ 8.
- `COLS`, 7: board columns.
- `ROWS`, 6: board rows.
- `ORIGIN_X`, 96: left pixel of board and header.
- `ORIGIN_Y`, 32: top pixel of header row. Board row 0 starts at `ORIGIN_Y+CELL_SIZE`.
- `BLINK_FRAMES`, 30: frames per blink half-period, ≥ 1.
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `video_on` in 1: active display region.
- `pixel_x` in 10: current pixel column.
- `pixel_y` in 10: current pixel row.
- `frame_start` in 1: one-cycle pulse at the start of each frame.
- `grid` in 2 × [ROWS][COLS]: cell state. 00 empty, 01 P1, 10 P2, 11 treated as empty.
- `cursor_col` in $clog2(COLS): column of the header disc.
- `cursor_player` in 2: header disc colour code, same encoding as `grid`.
- `win_mask` in ROWS*COLS: bit `row*COLS+col` set marks a winning cell.
- `r`, `g`, `b` out 8 each: registered pixel colour.

## Operation
- Stage 1 registers the following, all computed from the `pixel_x`/`pixel_y` sampled that cycle:
  - `in_hdr`: y in [ORIGIN_Y, ORIGIN_Y+CELL_SIZE-1] and x in board span.
  - `in_board`: y in [ORIGIN_Y+CELL_SIZE, ORIGIN_Y+(ROWS+1)*CELL_SIZE-1] and x in [ORIGIN_X, ORIGIN_X+COLS*CELL_SIZE-1].
  - Cell column and row: (x−ORIGIN_X)/CELL_SIZE, and row relative to board top.
  - In-cell offsets `ox`/`oy` in [0, CELL_SIZE-1].
  - The selected `grid` value, win bit, and the delayed `video_on`.
- Disc test: `dx = ox − CELL_SIZE/2` and `dy = oy − CELL_SIZE/2`, both signed. The pixel is inside the disc when `dx²+dy² ≤ R²`, with `R = (CELL_SIZE*3)/8` (integer division). Square and sum widths must hold `2*CELL_SIZE²` with no overflow.
- Stage 2 colour priority:
  - delayed `video_on`=0 → 000000
  - outside header and board → 000000
  - header, `col == cursor_col`, inside disc, `cursor_player` ∈ {01,10} → that player's colour; otherwise header pixel → 000000
  - board, outside disc → 0000FF
  - board, inside disc, win bit set and `blink_phase`=1 → FFFFFF
  - board, inside disc: 01 → FF0000; 10 → FFFF00; 00/11 → 202020
- `cursor_col ≥ COLS` → no cursor drawn.
- Blink counter `fcnt` counts 0..BLINK_FRAMES−1 on each `frame_start`. When `fcnt == BLINK_FRAMES−1`, `fcnt` goes to 0 and `blink_phase` toggles. With `BLINK_FRAMES=1` the phase toggles every frame.
- Elaboration check: `ORIGIN_X+COLS*CELL_SIZE ≤ 1024` and `ORIGIN_Y+(ROWS+1)*CELL_SIZE ≤ 1024`; fatal otherwise.

## Timing
- Latency: pixel, `video_on`, `grid`, cursor and `win_mask` sampled at edge N → `r`/`g`/`b` valid after edge N+1. The pipeline is two registers, throughput one pixel per clock.
- `blink_phase` is read in stage 2. A toggle at edge N affects pixels whose stage 2 completes after edge N.
- Reset (`rst_n`=0, asynchronous): `r`=`g`=`b`=0, all pipeline registers 0 (including the delayed `video_on`), `fcnt`=0, `blink_phase`=0.
  - Reset asserted mid-frame blanks the output immediately.
  - After release the first two pixels output black.
- `frame_start` during reset is ignored.

## Configuration
- `BOARD_RENDERER_WIN_BLINK_EN` defined: `fcnt`, `blink_phase` and the win-highlight rule are present as above.
- Undefined: no blink logic is instantiated, `win_mask` is ignored, and winning cells render in their player colour.

## Test plan
- Defaults, `grid[0][0]=01`, `video_on`=1, pixel (128,128) → FF0000 two edges later.
- Same cell, pixel (96,96) (corner, dx=dy=−32, 2048 > 576) → 0000FF. Pixel (10,10) → 000000. `grid[0][0]=00` at centre → 202020.
- `cursor_col=3`, `cursor_player=10`, pixel (320,64) → FFFF00. `cursor_col=7` at the same pixel → 000000.
- Macro on, `BLINK_FRAMES=2`, `win_mask[0]=1`, `grid[0][0]=01`, pixel (128,128):
  - after 2 `frame_start` pulses → FFFFFF
  - after 2 more → FF0000
  - macro off → always FF0000
- `video_on`=0 at (128,128) → 000000.
- Assert `rst_n`=0 mid-stream → `r`/`g`/`b`=0 with no clock edge. After release, the first valid colour appears on the second edge.

Source files
------------

// File: rtl/board_renderer.sv
// board_renderer: Connect-Four pixel renderer with a two-stage registered pipeline.
// Optional feature macro: BOARD_RENDERER_WIN_BLINK_EN (blinking highlight of winning cells).
module board_renderer #(
    parameter int CELL_SIZE    = 64,
    parameter int COLS         = 7,
    parameter int ROWS         = 6,
    parameter int ORIGIN_X     = 96,
    parameter int ORIGIN_Y     = 32,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 video_on,
    input  logic [9:0]                           pixel_x,
    input  logic [9:0]                           pixel_y,
    input  logic                                 frame_start,
    input  logic [ROWS-1:0][COLS-1:0][1:0]       grid,
    input  logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0] cursor_col,
    input  logic [1:0]                           cursor_player,
    input  logic [ROWS*COLS-1:0]                 win_mask,
    output logic [7:0]                           r,
    output logic [7:0]                           g,
    output logic [7:0]                           b
);
    localparam int CLW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int RW  = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int OW  = $clog2(CELL_SIZE);
    localparam int RAD = (CELL_SIZE * 3) / 8;

    if (ORIGIN_X + COLS * CELL_SIZE > 1024 || ORIGIN_Y + (ROWS + 1) * CELL_SIZE > 1024 ||
        CELL_SIZE < 8 || BLINK_FRAMES < 1) begin : g_bad_geom
        $fatal(1, "board_renderer: geometry exceeds the 1024x1024 pixel space or bad parameters");
    end

    int              xr, yh, yb, dx, dy;
    logic            x_in, hdr_c, brd_c, in_disc, blink_hit;
    logic [CLW-1:0]  col_c;
    logic [RW-1:0]   row_c;
    logic [OW-1:0]   ox_c, oy_c, ox_q, oy_q;
    logic [1:0]      cell_c, cell_q;
    logic            von_q, hdr_q, brd_q;
    logic [23:0]     rgb_c;

    // Map the pixel to header/board region, cell and in-cell offset; header cells carry the cursor colour
    always_comb begin
        xr     = int'(pixel_x) - ORIGIN_X;
        yh     = int'(pixel_y) - ORIGIN_Y;
        yb     = yh - CELL_SIZE;
        x_in   = xr >= 0 && xr < COLS * CELL_SIZE;
        hdr_c  = x_in && yh >= 0 && yh < CELL_SIZE;
        brd_c  = x_in && yb >= 0 && yb < ROWS * CELL_SIZE;
        col_c  = x_in ? CLW'(xr / CELL_SIZE) : '0;
        row_c  = brd_c ? RW'(yb / CELL_SIZE) : '0;
        ox_c   = OW'(xr % CELL_SIZE);
        oy_c   = OW'(hdr_c ? yh : yb % CELL_SIZE);
        cell_c = brd_c ? grid[row_c][col_c] :
                 (hdr_c && int'(cursor_col) < COLS && cursor_col == col_c) ? cursor_player : 2'b00;
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            von_q  <= 1'b0;
            hdr_q  <= 1'b0;
            brd_q  <= 1'b0;
            ox_q   <= '0;
            oy_q   <= '0;
            cell_q <= 2'b00;
        end else begin
            von_q  <= video_on;
            hdr_q  <= hdr_c;
            brd_q  <= brd_c;
            ox_q   <= ox_c;
            oy_q   <= oy_c;
            cell_q <= cell_c;
        end
    end

`ifdef BOARD_RENDERER_WIN_BLINK_EN
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam int WW = ROWS * COLS > 1 ? $clog2(ROWS * COLS) : 1;
    logic          win_q, blink_phase;
    logic [FW-1:0] fcnt;
    logic [WW-1:0] wi_c;
    assign wi_c      = WW'(int'(row_c) * COLS + int'(col_c));
    assign blink_hit = win_q & blink_phase;

    // Win bit pipeline and frame-counted blink phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= 1'b0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
        end else begin
            win_q <= brd_c & win_mask[wi_c];
            if (frame_start) begin
                fcnt        <= (fcnt == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
                blink_phase <= (fcnt == FW'(BLINK_FRAMES - 1)) ? ~blink_phase : blink_phase;
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^{win_mask, frame_start};
    assign blink_hit    = 1'b0;
`endif

    // Disc test and colour priority for the pixel held in stage 1
    always_comb begin
        dx      = int'(ox_q) - CELL_SIZE / 2;
        dy      = int'(oy_q) - CELL_SIZE / 2;
        in_disc = dx * dx + dy * dy <= RAD * RAD;
        rgb_c   = 24'h000000;
        if (von_q && hdr_q && in_disc)
            rgb_c = cell_q == 2'b01 ? 24'hFF0000 : cell_q == 2'b10 ? 24'hFFFF00 : 24'h000000;
        else if (von_q && brd_q)
            rgb_c = !in_disc ? 24'h0000FF : blink_hit ? 24'hFFFFFF :
                    cell_q == 2'b01 ? 24'hFF0000 : cell_q == 2'b10 ? 24'hFFFF00 : 24'h202020;
    end

    // Stage 2 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {r, g, b} <= 24'h000000;
        else        {r, g, b} <= rgb_c;
    end
endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer: scoreboard bench for board_renderer with directed pixel vectors.
module tb_board_renderer;
`ifdef BOARD_RENDERER_WIN_BLINK_EN
    localparam logic [23:0] BLINK_ON = 24'hFFFFFF;
`else
    localparam logic [23:0] BLINK_ON = 24'hFF0000;
`endif

    logic                 clk = 1'b0, rst_n = 1'b1, video_on = 1'b0, frame_start = 1'b0;
    logic [9:0]           pixel_x = '0, pixel_y = '0;
    logic [5:0][6:0][1:0] grid = '0;
    logic [2:0]           cursor_col = 3'd7;
    logic [1:0]           cursor_player = 2'b00;
    logic [41:0]          win_mask = '0;
    logic [7:0]           r, g, b;
    int                   total = 0, bad = 0;
    logic [23:0]          exp_q[$];
    string                name_q[$];
    logic                 chk = 1'b0, v1, v2;

    always #5 clk = ~clk;

    board_renderer #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .grid(grid), .cursor_col(cursor_col),
        .cursor_player(cursor_player), .win_mask(win_mask), .r(r), .g(g), .b(b)
    );

    // Track which issued pixels are due at the output two edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= chk;
            v2 <= v1;
        end
    end

    // Monitor: pop and compare when a tracked pixel reaches the output
    always @(negedge clk) begin
        if (v2) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output got=%06h with empty scoreboard", {r, g, b});
            end else begin
                logic [23:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({r, g, b} !== e) begin
                    bad++;
                    $display("FAIL %s got=%06h exp=%06h", nm, {r, g, b}, e);
                end
            end
        end
    end

    task automatic check_now(input string nm, input logic [23:0] e);
        total++;
        if ({r, g, b} !== e) begin
            bad++;
            $display("FAIL %s got=%06h exp=%06h", nm, {r, g, b}, e);
        end
    endtask

    task automatic drive(input int x, input int y, input logic von, input logic c,
                         input logic [23:0] e, input string nm);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        chk      = c;
        if (c) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(negedge clk);
    endtask

    task automatic pulse_frames(input int n);
        chk = 1'b0;
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_now("reset_rgb", 24'h000000);
        grid[0][0] = 2'b01;
        grid[0][1] = 2'b01;
        rst_n = 1'b1;
        drive(128, 128, 1, 1, 24'hFF0000, "center_p1");
        drive(96, 96, 1, 1, 24'h0000FF, "corner_blue");
        drive(10, 10, 1, 1, 24'h000000, "outside");
        drive(128, 128, 0, 1, 24'h000000, "video_off");
        drive(152, 128, 1, 1, 24'hFF0000, "disc_edge_in");
        drive(153, 128, 1, 1, 24'h0000FF, "disc_edge_out");
        drive(128, 104, 1, 1, 24'hFF0000, "disc_top_in");
        drive(128, 103, 1, 1, 24'h0000FF, "disc_top_out");
        grid[0][0] = 2'b00;
        drive(128, 128, 1, 1, 24'h202020, "empty_grey");
        grid[0][0] = 2'b11;
        drive(128, 128, 1, 1, 24'h202020, "code11_grey");
        grid[0][0] = 2'b10;
        drive(128, 128, 1, 1, 24'hFFFF00, "p2_yellow");
        grid[5][6] = 2'b01;
        drive(512, 448, 1, 1, 24'hFF0000, "last_cell");
        drive(543, 448, 1, 1, 24'h0000FF, "right_edge_in");
        drive(544, 448, 1, 1, 24'h000000, "right_edge_out");
        drive(512, 479, 1, 1, 24'h0000FF, "bottom_edge_in");
        drive(512, 480, 1, 1, 24'h000000, "below_board");
        cursor_col = 3'd3;
        cursor_player = 2'b10;
        drive(320, 64, 1, 1, 24'hFFFF00, "cursor_p2");
        cursor_player = 2'b01;
        drive(320, 64, 1, 1, 24'hFF0000, "cursor_p1");
        cursor_player = 2'b00;
        drive(320, 64, 1, 1, 24'h000000, "cursor_empty");
        cursor_player = 2'b11;
        drive(320, 64, 1, 1, 24'h000000, "cursor_code11");
        cursor_player = 2'b10;
        drive(288, 64, 1, 1, 24'h000000, "cursor_other_col");
        drive(320, 32, 1, 1, 24'h000000, "cursor_corner");
        drive(320, 31, 1, 1, 24'h000000, "above_header");
        cursor_col = 3'd7;
        drive(320, 64, 1, 1, 24'h000000, "cursor_out_of_range");

        grid[0][0] = 2'b01;
        win_mask[0] = 1'b1;
        drive(128, 128, 1, 1, 24'hFF0000, "blink_phase0");
        pulse_frames(2);
        drive(128, 128, 1, 1, BLINK_ON, "blink_phase1");
        drive(96, 96, 1, 1, 24'h0000FF, "blink_outside_disc");
        drive(192, 128, 1, 1, 24'hFF0000, "blink_nonwin_cell");
        pulse_frames(1);
        drive(128, 128, 1, 1, BLINK_ON, "blink_hold");
        pulse_frames(1);
        drive(128, 128, 1, 1, 24'hFF0000, "blink_phase_back");
        pulse_frames(2);
        repeat (3) drive(128, 128, 1, 0, 24'h000000, "");
        check_now("pre_reset_stream", BLINK_ON);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset_blank", 24'h000000);
        @(negedge clk);
        pulse_frames(2);
        rst_n = 1'b1;
        drive(128, 128, 1, 1, 24'hFF0000, "post_reset_first_colour");
        check_now("post_reset_first_black", 24'h000000);
        pulse_frames(1);
        drive(128, 128, 1, 1, 24'hFF0000, "one_frame_no_toggle");
        pulse_frames(1);
        drive(128, 128, 1, 1, BLINK_ON, "two_frames_toggle");
        chk = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
